round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the number of request channels (N >= 2).
REQ-002 The module SHALL have parameter IW, default 2, giving the index width, set by the instantiator to ceil(log2(N)).
REQ-003 The module SHALL have parameter MODE, default 1, selecting priority: 0 = fixed (channel 0 highest), 1 = round-robin.
REQ-004 The module SHALL have parameter MAX_HOLD, default 0, giving the forced-release limit in cycles; 0 disables preemption.
REQ-005 The module SHALL have parameter CW, default 8, giving the hold-counter width, with MAX_HOLD < 2**CW.
REQ-006 clock  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge).
REQ-008 req  input  N  request lines, one per channel; req[i] high = channel i wants or keeps the resource.
REQ-009 grant  output  N  registered one-hot grant; all-zero when idle.
REQ-010 grant_idx  output  IW  registered binary index of the granted channel; 0 when idle.
REQ-011 valid  output  1  registered; high when exactly one grant bit is set.

Function
REQ-012 The arbiter SHALL be a two-state machine, IDLE and BUSY, with outputs driven only from registers (no combinational req-to-grant path).
REQ-013 In IDLE, on any edge with req != 0, the arbiter SHALL select a winner, drive grant/grant_idx/valid on the next cycle, enter BUSY and set hold_cnt = 1.
REQ-014 In IDLE with req == 0, state and outputs SHALL remain unchanged.
REQ-015 Winner selection in MODE 0 SHALL choose the lowest-index asserted candidate.
REQ-016 Winner selection in MODE 1 SHALL choose the first asserted candidate searching ptr, ptr+1, ..., wrapping from N-1 to 0.
REQ-017 On every new grant to channel w, ptr SHALL become (w+1) mod N; ptr SHALL stay 0 in MODE 0.
REQ-018 In BUSY, if req[grant_idx] == 1 and no preemption applies, the grant SHALL be held and hold_cnt SHALL increment, saturating at 2**CW-1.
REQ-019 In BUSY, if req[grant_idx] == 0 and req != 0, the arbiter SHALL grant a new winner on the next cycle with no idle bubble, set hold_cnt = 1 and stay BUSY.
REQ-020 In BUSY, if req == 0, the arbiter SHALL return to IDLE and clear grant, grant_idx and valid on the next cycle.
REQ-021 Preemption: if MAX_HOLD != 0, hold_cnt == MAX_HOLD and (req & ~grant) != 0, the arbiter SHALL regrant to the winner among req & ~grant and set hold_cnt = 1.
REQ-022 If the holder is at the limit and no other channel requests, the grant SHALL be kept and hold_cnt SHALL stay at MAX_HOLD.
REQ-023 grant SHALL never have more than one bit set; valid SHALL equal |grant at all times.
REQ-024 Request changes take effect at the next rising edge only; latency from req to grant SHALL be exactly 1 cycle.

Reset
REQ-025 On a rising edge with reset == 0, the arbiter SHALL set state = IDLE, grant = 0, grant_idx = 0, valid = 0, ptr = 0 and hold_cnt = 0, regardless of req.
REQ-026 Reset SHALL take priority over all other transitions, including mid-grant and preemption.
REQ-027 After reset deasserts, arbitration SHALL start at channel 0 in both modes.

Verification (N=4, IW=2)
REQ-028 Reset: reset=0 with req=4'b1111 for 2 cycles -> grant=0000, grant_idx=0, valid=0; release with req=4'b0100 -> next cycle grant=0100, grant_idx=2, valid=1.
REQ-029 Round-robin preemption: MODE=1, MAX_HOLD=4, req held at 4'b1111 -> grant 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001.
REQ-030 Fixed priority: MODE=0, req=4'b1010 -> grant=0010; drop req[1] (req=1000) -> next cycle grant=1000 with no idle cycle; req=0000 -> next cycle valid=0.
REQ-031 Wrap-around: MODE=1, last grant idx 3 released, req=4'b1001 -> grant_idx=0 (ptr wraps), not 3.
REQ-032 Reset mid-operation: grant=0100 in BUSY, reset=0 for one edge -> outputs cleared next cycle; then req=4'b0110 -> grant=0010 (ptr restarted at 0).
REQ-033 Lone holder: MAX_HOLD=2, req=4'b0001 held for 10 cycles -> grant stays 0001 throughout; valid stays 1.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// N-channel arbiter, fixed or round-robin priority, registered one-hot grant
// with optional forced release after MAX_HOLD cycles of continuous ownership.
module round_robin_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IW       = 2,
    parameter int unsigned MODE     = 1,
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned CW       = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_MAX   = {CW{1'b1}};
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [IW-1:0] r_grant_idx, w_grant_idx_nxt;
    logic          r_valid, w_valid_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_hold_cnt, w_hold_cnt_nxt;

    logic [N-1:0]  w_others;
    logic [IW-1:0] w_search_start;
    logic [IW-1:0] w_req_win;
    logic [IW-1:0] w_oth_win;
    logic          w_load;
    logic [IW-1:0] w_load_idx;

    // First asserted candidate in search order start, start+1, ... wrapping at N-1.
    function automatic logic [IW-1:0] pick_winner(input logic [N-1:0]  cand,
                                                  input logic [IW-1:0] start);
        logic [IW-1:0] win;
        int unsigned   j;
        win = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            j = 32'(start) + 32'(k);
            if (j >= N) j = j - N;
            if (cand[IW'(j)]) win = IW'(j);
        end
        return win;
    endfunction

    always_comb begin
        w_others       = i_req & ~r_grant;
        w_search_start = (MODE == 1) ? r_ptr : '0;
        w_req_win      = pick_winner(i_req, w_search_start);
        w_oth_win      = pick_winner(w_others, w_search_start);
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_valid_nxt     = r_valid;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_load          = 1'b0;
        w_load_idx      = w_req_win;

        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_load     = 1'b1;
                    w_load_idx = w_req_win;
                end
            end
            ST_BUSY: begin
                if (!(|i_req)) begin
                    w_state_nxt     = ST_IDLE;
                    w_grant_nxt     = '0;
                    w_grant_idx_nxt = '0;
                    w_valid_nxt     = 1'b0;
                end else if (i_req[r_grant_idx]) begin
                    if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIMIT)) begin
                        // At the limit: hand over only if someone else is waiting.
                        if (|w_others) begin
                            w_load     = 1'b1;
                            w_load_idx = w_oth_win;
                        end
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_cnt_nxt = r_hold_cnt + CW'(1);
                    end
                end else begin
                    w_load     = 1'b1;
                    w_load_idx = w_req_win;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt     = ST_BUSY;
            w_grant_nxt     = N'(1) << w_load_idx;
            w_grant_idx_nxt = w_load_idx;
            w_valid_nxt     = 1'b1;
            w_hold_cnt_nxt  = CW'(1);
            if (MODE == 1) begin
                w_ptr_nxt = (w_load_idx == LAST_IDX) ? '0 : w_load_idx + IW'(1);
            end else begin
                w_ptr_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_valid     <= 1'b0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_valid     <= w_valid_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_idx = r_grant_idx;
    assign o_valid     = r_valid;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: three configurations (round-robin with hold limit 4,
// fixed priority, round-robin with hold limit 2) driven from a vector table.
module tb_round_robin_arbiter;

    logic       clk;
    logic       rst_n [3];
    logic [3:0] req   [3];
    logic [3:0] gnt   [3];
    logic [1:0] gidx  [3];
    logic       vld   [3];

    int errors;
    int checks;

    typedef struct {
        int         sel;
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_idx;
        logic       exp_valid;
    } vec_t;

    typedef struct {
        int         vec_no;
        int         sel;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    round_robin_arbiter #(.N(4), .IW(2), .MODE(1), .MAX_HOLD(4), .CW(8)) u_rr (
        .i_clock(clk), .i_reset(rst_n[0]), .i_req(req[0]),
        .o_grant(gnt[0]), .o_grant_idx(gidx[0]), .o_valid(vld[0])
    );

    round_robin_arbiter #(.N(4), .IW(2), .MODE(0), .MAX_HOLD(0), .CW(8)) u_fx (
        .i_clock(clk), .i_reset(rst_n[1]), .i_req(req[1]),
        .o_grant(gnt[1]), .o_grant_idx(gidx[1]), .o_valid(vld[1])
    );

    round_robin_arbiter #(.N(4), .IW(2), .MODE(1), .MAX_HOLD(2), .CW(8)) u_lh (
        .i_clock(clk), .i_reset(rst_n[2]), .i_req(req[2]),
        .o_grant(gnt[2]), .o_grant_idx(gidx[2]), .o_valid(vld[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected index/valid follow directly from the expected one-hot grant.
    function automatic void add(input int sel, input logic r, input logic [3:0] rq,
                                input logic [3:0] g);
        vec_t v;
        v.sel       = sel;
        v.rst_n     = r;
        v.req       = rq;
        v.exp_grant = g;
        v.exp_valid = (g != 4'b0000);
        v.exp_idx   = 2'd0;
        for (int b = 0; b < 4; b++) if (g[b]) v.exp_idx = 2'(b);
        vecs.push_back(v);
    endfunction

    task automatic check_out(input exp_t e);
        logic [3:0] ag;
        logic [1:0] ai;
        logic       av;
        ag = gnt[e.sel];
        ai = gidx[e.sel];
        av = vld[e.sel];
        checks++;
        if (ag !== e.grant) begin
            errors++;
            $display("FAIL vec%0d dut%0d grant: got %b want %b", e.vec_no, e.sel, ag, e.grant);
        end
        checks++;
        if (ai !== e.idx) begin
            errors++;
            $display("FAIL vec%0d dut%0d grant_idx: got %0d want %0d", e.vec_no, e.sel, ai, e.idx);
        end
        checks++;
        if (av !== e.valid) begin
            errors++;
            $display("FAIL vec%0d dut%0d valid: got %b want %b", e.vec_no, e.sel, av, e.valid);
        end
        checks++;
        if (($countones(ag) > 1) || (av !== (|ag))) begin
            errors++;
            $display("FAIL vec%0d dut%0d onehot/valid: grant %b valid %b", e.vec_no, e.sel, ag, av);
        end
    endtask

    initial begin
        exp_t e;
        errors = 0;
        checks = 0;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            req[d]   = 4'b0000;
        end

        // Reset with all requesting, then release toward channel 2.
        add(0, 1'b0, 4'b1111, 4'b0000);
        add(0, 1'b0, 4'b1111, 4'b0000);
        add(0, 1'b1, 4'b0100, 4'b0100);
        add(0, 1'b1, 4'b0000, 4'b0000);
        // Round-robin with forced release every 4 cycles.
        add(0, 1'b0, 4'b0000, 4'b0000);
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++)
            add(0, 1'b1, 4'b1111, 4'b0001 << c);
        add(0, 1'b1, 4'b1111, 4'b0001);
        // Wrap-around: channel 3 granted then released, ptr wraps to 0.
        add(0, 1'b1, 4'b1000, 4'b1000);
        add(0, 1'b1, 4'b0000, 4'b0000);
        add(0, 1'b1, 4'b1001, 4'b0001);
        // Reset mid-grant restarts the pointer at 0.
        add(0, 1'b0, 4'b0000, 4'b0000);
        add(0, 1'b1, 4'b0100, 4'b0100);
        add(0, 1'b1, 4'b0100, 4'b0100);
        add(0, 1'b0, 4'b0100, 4'b0000);
        add(0, 1'b1, 4'b0110, 4'b0010);

        // Fixed priority, handover without bubble, no preemption.
        add(1, 1'b0, 4'b0000, 4'b0000);
        add(1, 1'b1, 4'b1010, 4'b0010);
        add(1, 1'b1, 4'b1000, 4'b1000);
        add(1, 1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) add(1, 1'b1, 4'b1111, 4'b0001);
        add(1, 1'b1, 4'b1110, 4'b0010);

        // Lone holder at hold limit 2 keeps the grant, then others arrive.
        add(2, 1'b0, 4'b0000, 4'b0000);
        for (int k = 0; k < 10; k++) add(2, 1'b1, 4'b0001, 4'b0001);
        add(2, 1'b1, 4'b0011, 4'b0010);
        add(2, 1'b1, 4'b0011, 4'b0010);
        add(2, 1'b1, 4'b0011, 4'b0001);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n[vecs[i].sel] = vecs[i].rst_n;
            req[vecs[i].sel]   = vecs[i].req;
            e.vec_no = i;
            e.sel    = vecs[i].sel;
            e.grant  = vecs[i].exp_grant;
            e.idx    = vecs[i].exp_idx;
            e.valid  = vecs[i].exp_valid;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard empty at vec%0d", i);
            end else begin
                check_out(sb.pop_front());
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
